// File: rtl/clk_div_ctrl_if.sv
// Ratio-change request channel from the receiver configuration logic to clk_div_ctrl.
// The master offers a ratio with valid; the slave consumes it on a cycle where ready is high.
interface clk_div_ctrl_if;
  logic       valid;
  logic [5:0] ratio;
  logic       ready;

  modport master (
    output valid,
    output ratio,
    input  ready
  );

  modport slave (
    input  valid,
    input  ratio,
    output ready
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Enable/ratio controller for the receiver clock divider: glitch-safe ratio changes
// (gate, guard, load, re-enable, warm up) plus a reference-domain divided-period strobe.
module clk_div_ctrl #(
  parameter logic [5:0]  DEFAULT_RATIO = 6'd2,
  parameter logic [5:0]  MAX_RATIO     = 6'd32,
  parameter int unsigned GUARD_CYCLES  = 4
) (
  input  logic         i_ref_clk,
  input  logic         i_rst_n,
  input  logic         i_enable,
  clk_div_ctrl_if.slave req,
  output logic [5:0]   o_div_ratio,
  output logic         o_clk_en,
  output logic         o_locked,
  output logic         o_busy,
  output logic         o_err,
  output logic         o_tick
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_GUARD = 3'd1,
    S_LOAD  = 3'd2,
    S_WARM  = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [5:0] ratio_q, ratio_d;
  logic [5:0] pending_q, pending_d;
  logic [3:0] guard_q, guard_d;
  logic [6:0] warm_q, warm_d;
  logic [5:0] tick_cnt_q, tick_cnt_d;
  logic       clk_en_q, locked_q, busy_q, err_q, tick_q, ready_q;
  logic       clk_en_d, locked_d, busy_d, err_d, tick_d, ready_d;
  logic       accept, legal;

  always_comb begin
    state_d   = state_q;
    ratio_d   = ratio_q;
    pending_d = pending_q;
    guard_d   = guard_q;
    warm_d    = warm_q;
    accept    = req.valid && ready_q;
    legal     = (req.ratio <= MAX_RATIO);
    err_d     = accept && !legal;

    if (!i_enable) begin
      // Disable wins everywhere; only an idle controller may still take a new ratio.
      state_d = S_OFF;
      if (state_q == S_OFF && accept && legal) begin
        ratio_d = req.ratio;
      end
    end else begin
      unique case (state_q)
        S_OFF: begin
          if (accept && legal) begin
            ratio_d = req.ratio;
          end
          state_d = S_WARM;
        end
        S_RUN: begin
          if (accept && legal && req.ratio != ratio_q) begin
            pending_d = req.ratio;
            guard_d   = GUARD_INIT;
            state_d   = S_GUARD;
          end
        end
        S_GUARD: begin
          // Ratio moves on the edge leaving the guard so it is settled a cycle before enable.
          if (guard_q == 4'd0) begin
            ratio_d = pending_q;
            state_d = S_LOAD;
          end else begin
            guard_d = guard_q - 4'd1;
          end
        end
        S_LOAD: begin
          state_d = S_WARM;
        end
        S_WARM: begin
          if (warm_q == 7'd0) begin
            state_d = S_RUN;
          end else begin
            warm_d = warm_q - 7'd1;
          end
        end
        default: begin
          state_d = S_OFF;
        end
      endcase
    end

    if (state_d == S_WARM && state_q != S_WARM) begin
      warm_d = (ratio_d < 6'd2) ? 7'd1 : ({ratio_d, 1'b0} - 7'd1);
    end

    clk_en_d = (state_d == S_WARM) || (state_d == S_RUN);
    locked_d = (state_d == S_RUN);
    busy_d   = (state_d == S_GUARD) || (state_d == S_LOAD) || (state_d == S_WARM);
    ready_d  = (state_d == S_OFF) || (state_d == S_RUN);
  end

  // Tick counter runs only while the divider is enabled, so it restarts on every enable rise.
  always_comb begin
    tick_cnt_d = 6'd0;
    tick_d     = 1'b0;
    if (clk_en_q) begin
      if (ratio_q == 6'd1) begin
        tick_d = 1'b1;
      end else if (ratio_q >= 6'd2) begin
        if (tick_cnt_q == ratio_q - 6'd1) begin
          tick_d = 1'b1;
        end else begin
          tick_cnt_d = tick_cnt_q + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_OFF;
      ratio_q    <= DEFAULT_RATIO;
      pending_q  <= DEFAULT_RATIO;
      guard_q    <= 4'd0;
      warm_q     <= 7'd0;
      tick_cnt_q <= 6'd0;
      clk_en_q   <= 1'b0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      tick_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      ratio_q    <= ratio_d;
      pending_q  <= pending_d;
      guard_q    <= guard_d;
      warm_q     <= warm_d;
      tick_cnt_q <= tick_cnt_d;
      clk_en_q   <= clk_en_d;
      locked_q   <= locked_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      tick_q     <= tick_d;
      ready_q    <= ready_d;
    end
  end

  assign req.ready   = ready_q;
  assign o_div_ratio = ratio_q;
  assign o_clk_en    = clk_en_q;
  assign o_locked    = locked_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;
  assign o_tick      = tick_q;

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Control stage directly upstream of the receiver's programmable clock divider: it drives the divider's enable and 6-bit division ratio. Ratio changes arrive from the receiver configuration logic through a valid/ready handshake. The block applies them glitch-safely: gate the divider, hold a guard interval, load the new ratio, re-enable, then wait a warm-up interval before declaring lock. It also issues a reference-domain strobe once per divided-clock period for downstream sample-rate logic.

## Interface
- DEFAULT_RATIO, 6'd2: ratio driven after reset.
- MAX_RATIO, 6'd32: largest legal requested ratio.
- GUARD_CYCLES, 4: i_ref_clk cycles the divider is held disabled before a new ratio is loaded (legal range 1..15).
- i_ref_clk  in  1  reference clock; all logic on its rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_enable  in  1  global run request for the divided clock.
- i_req_valid  in  1  ratio-change request valid.
- i_req_ratio  in  6  requested division ratio.
- o_req_ready  out  1  request may be accepted this cycle.
- o_div_ratio  out  6  ratio to divider (registered).
- o_clk_en  out  1  enable to divider (registered).
- o_locked  out  1  divider running at a stable ratio.
- o_busy  out  1  ratio change in progress.
- o_err  out  1  one-cycle pulse: accepted request rejected as illegal.
- o_tick  out  1  one-cycle strobe per divided-clock period.

## Operation
- All outputs are registered. Reset values:
  - State OFF; o_div_ratio=DEFAULT_RATIO.
  - o_clk_en, o_locked, o_busy, o_err and o_tick all 0.
  - o_req_ready=1.
- A request is accepted on a rising edge where i_req_valid && o_req_ready. o_req_ready=1 only in OFF and RUN.
- Legality: i_req_ratio > MAX_RATIO is illegal. An illegal request is still accepted (consumed) but:
  - o_err pulses one cycle;
  - no state or ratio change occurs.
- The legal ratios 0 and 1 are passed through unchanged. The divider interprets them: 0 = output held low, 1 = pass-through.
- FSM states: OFF, GUARD, LOAD, WARM, RUN.
  - OFF: o_clk_en=0.
    - Legal accepted request: o_div_ratio updated on the next edge, no gating.
    - i_enable=1: go to WARM with o_clk_en=1. If a request is accepted on the same edge, the new ratio is loaded simultaneously.
  - RUN: o_clk_en=1, o_locked=1.
    - Legal request equal to o_div_ratio: acknowledged, no-op, stay in RUN.
    - Legal request that differs: latch it as pending; go to GUARD with o_clk_en=0 and guard counter=GUARD_CYCLES-1.
  - GUARD: decrement the counter each edge. At 0, go to LOAD.
  - LOAD: o_div_ratio<=pending; go to WARM with o_clk_en=1.
  - WARM: on entry, warm counter = 2*o_div_ratio-1 (7-bit), or 1 if ratio<2. Decrement each edge; at 0, go to RUN.
- o_busy=1 in GUARD, LOAD and WARM. o_locked=1 only in RUN.
- i_enable=0 in any state: go to OFF on the next edge.
  - o_clk_en, o_locked and o_busy all go to 0.
  - Any pending ratio not yet loaded is discarded; o_div_ratio keeps its last value.
  - i_enable has priority over request handling in RUN.
- Tick generator:
  - Counter cleared while o_clk_en=0.
  - While o_clk_en=1 and ratio>=2: o_tick pulses every o_div_ratio cycles, first pulse o_div_ratio cycles after o_clk_en rises.
  - Ratio 1: o_tick=1 every cycle. Ratio 0: o_tick=0.
  - The counter restarts whenever o_clk_en rises.

## Timing
- Ratio change accepted in RUN at edge T, with G=GUARD_CYCLES and new ratio R:
  - o_clk_en=0 after edge T.
  - o_div_ratio=new after edge T+G.
  - o_clk_en=1 after edge T+G+1.
  - o_locked=1 after edge T+G+1+max(2R,2).
- Guarantees:
  - The divider sees enable low for G full cycles before the ratio changes.
  - The ratio is stable 1 cycle before enable rises.
- OFF->enable at edge T: o_clk_en=1 after T; o_locked after T+max(2R,2).
- o_err is asserted in the cycle after the accepting edge.

## Test plan
- Reset, then release with i_enable=0 -> o_div_ratio=2, o_clk_en=0, o_req_ready=1, all other outputs 0.
- In OFF: request 6, then raise i_enable -> o_div_ratio=6 one edge after acceptance; o_clk_en=1 one edge after i_enable; o_locked 12 cycles later; o_tick every 6 cycles.
- In RUN at ratio 6, request 4 at edge T (G=4) ->
  - o_clk_en low from T through T+4;
  - o_div_ratio=4 after T+4;
  - o_clk_en=1 after T+5;
  - o_locked after T+13;
  - o_req_ready=0 throughout.
- In RUN at ratio 4: request 4 -> ready stays 1, no gating. Request 40 -> o_err one pulse, ratio stays 4, o_locked stays 1.
- Drop i_enable during GUARD of a 4->10 change -> OFF next edge, o_clk_en=0, o_div_ratio stays 4. Re-enable -> WARM at ratio 4.
- Ratio 1 -> o_tick constant 1 while enabled. Ratio 0 -> o_tick 0; WARM lasts 2 cycles.
